// File: rtl/dev_feeder_if.sv
// Handshake and core-facing bus of the dev_feeder job scheduler.
// The master modport is the feeder's view; slave is the environment's view.
interface dev_feeder_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_x_bi;
  logic [31:0] in_y_bi;
  logic [31:0] core_x_bo;
  logic [31:0] core_y_bo;
  logic        core_start_o;
  logic        core_rdy_i;
  logic [31:0] core_res_bi;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_y_bo;

  modport master (
    input  in_valid_i, in_x_bi, in_y_bi, core_rdy_i, core_res_bi, out_ready_i,
    output in_ready_o, core_x_bo, core_y_bo, core_start_o, out_valid_o, out_y_bo
  );

  modport slave (
    output in_valid_i, in_x_bi, in_y_bi, core_rdy_i, core_res_bi, out_ready_i,
    input  in_ready_o, core_x_bo, core_y_bo, core_start_o, out_valid_o, out_y_bo
  );
endinterface

// File: rtl/dev_feeder.sv
// Job scheduler for the cube-root/multiply core: operand FIFO, one-job-at-a-time
// issue with a start pulse, single result slot, and a watchdog on the core handshake.
module dev_feeder #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dev_feeder_if.master     bus,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] done_cnt_o
);

  localparam int              WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

  logic [31:0]      mem_x [DEPTH];
  logic [31:0]      mem_y [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, empty, push, pop;

  state_t           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             issue, capture, abort;

  logic [31:0]      core_x_q, core_y_q, out_y_q;
  logic             core_start_q, out_valid_q, err_q;
  logic [CNT_W-1:0] done_cnt_q;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = bus.in_valid_i && !full;
  assign pop   = issue;

  assign bus.in_ready_o   = !full;
  assign bus.core_x_bo    = core_x_q;
  assign bus.core_y_bo    = core_y_q;
  assign bus.core_start_o = core_start_q;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_y_bo     = out_y_q;
  assign busy_o           = (state_q != IDLE) || !empty;
  assign err_o            = err_q;
  assign done_cnt_o       = done_cnt_q;

  // Operand storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_x[wr_ptr_q] <= bus.in_x_bi;
      mem_y[wr_ptr_q] <= bus.in_y_bi;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The watchdog is checked before the handshake so a stuck core always aborts.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    issue   = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !out_valid_q && bus.core_rdy_i) begin
          issue   = 1'b1;
          wd_d    = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (wd_q == WD_LIMIT) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (!bus.core_rdy_i) begin
          wd_d    = '0;
          state_d = WAIT_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (wd_q == WD_LIMIT) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (bus.core_rdy_i) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      wd_q         <= '0;
      core_start_q <= 1'b0;
      core_x_q     <= '0;
      core_y_q     <= '0;
      out_valid_q  <= 1'b0;
      out_y_q      <= '0;
      done_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      core_start_q <= issue;
      if (issue) begin
        core_x_q <= mem_x[rd_ptr_q];
        core_y_q <= mem_y[rd_ptr_q];
      end
      if (capture) begin
        out_valid_q <= 1'b1;
        out_y_q     <= bus.core_res_bi;
        done_cnt_q  <= done_cnt_q + 1'b1;
      end else if (out_valid_q && bus.out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      if (abort) err_q <= 1'b1;
    end
  end

endmodule

// File: doc/dev_feeder.md
Name: dev_feeder

Overview:
Upstream job scheduler for the iterative cube-root/multiply core (y = y_in * cbrt(x_in); 32-bit x/y operands, start/ready handshake). It accepts (x, y) operand pairs on a valid/ready stream and buffers them in a small FIFO. It issues one job at a time to the core with a single-cycle start pulse, captures each result, and presents it on a valid/ready output. A watchdog flags a core that never acknowledges or never completes.

Parameters:
DEPTH, 4, operand FIFO entries (power of 2, >=2)
AW, 2, FIFO pointer width, log2(DEPTH)
CNT_W, 16, width of completed-job counter
TIMEOUT, 1024, max cycles allowed in WAIT_ACK or WAIT_DONE before abort

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-low
in_valid_i  in  1  operand pair valid
in_ready_o  out  1  FIFO can accept (= !full)
in_x_bi  in  32  x operand
in_y_bi  in  32  y operand
core_x_bo  out  32  x to core
core_y_bo  out  32  y to core
core_start_o  out  1  one-cycle start pulse to core
core_rdy_i  in  1  core idle/done flag (high when idle)
core_res_bi  in  32  core result, valid when core_rdy_i rises
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts result
out_y_bo  out  32  result
busy_o  out  1  high whenever state != IDLE or FIFO non-empty
err_o  out  1  sticky watchdog error
done_cnt_o  out  CNT_W  completed jobs, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_i low, async): FIFO empty (pointers and count 0), state IDLE, core_x_bo/core_y_bo/out_y_bo = 0, core_start_o = 0, out_valid_o = 0, err_o = 0, done_cnt_o = 0, watchdog = 0. in_ready_o = 1 once reset deasserts.
- FIFO: push when in_valid_i && in_ready_o. Pop only on issue. When full, in_ready_o = 0; no bypass. Simultaneous push and pop when not full: count unchanged, both pointers advance. Pointers wrap at DEPTH.
- Output slot: out_valid_o set on capture, held with out_y_bo stable until out_valid_o && out_ready_i, then cleared next edge.
- FSM:
  - IDLE: if FIFO non-empty && !out_valid_o && core_rdy_i, register head x/y onto core_x_bo/core_y_bo, set core_start_o = 1, pop, watchdog = 0, go to WAIT_ACK.
  - WAIT_ACK: core_start_o = 0 (pulse is exactly 1 cycle). If !core_rdy_i, go to WAIT_DONE and clear the watchdog; otherwise increment the watchdog.
  - WAIT_DONE: if core_rdy_i, out_y_bo = core_res_bi, out_valid_o = 1, done_cnt_o++, go to IDLE; otherwise increment the watchdog.
  - Watchdog = TIMEOUT in WAIT_ACK or WAIT_DONE: err_o = 1 (sticky until reset), job dropped, no output, done_cnt_o unchanged, go to IDLE.
- Core timing: start registered at edge E1 is sampled by the core at E2; the core drops rdy after E2; the feeder sees it low at E3. The core raises rdy together with a valid result.
- Issue blocking: no new issue while out_valid_o = 1. A result consumed at edge E can be followed by an issue at E+1 at the earliest.
- core_x_bo/core_y_bo hold their last issued value between jobs.
- Reset mid-job: all state cleared immediately. The core is reset separately; the feeder makes no assumption about the in-flight job.
- Back-to-back throughput: one job per (core latency + 3) cycles when output is always ready.

Test Plan:
- Reset with rst_i low mid-WAIT_DONE -> all outputs at reset values immediately (async); after release, in_ready_o = 1, busy_o = 0, done_cnt_o = 0.
- Single job x=27, y=5 with real core -> exactly one core_start_o pulse of 1 cycle; out_y_bo = 15, out_valid_o = 1; done_cnt_o = 1.
- Push 4 jobs back-to-back, (64,3), (8,10), (1000,2), (1,7), out_ready_i = 1 -> in_ready_o low after 4th push if none issued yet; results 12, 20, 20, 7 in order; done_cnt_o = 4.
- Hold out_ready_i = 0 after first result -> out_valid_o and out_y_bo stable; no second core_start_o until out_ready_i pulses high.
- Core model holds core_rdy_i = 1 (never acks), TIMEOUT = 16 -> err_o = 1 after 16 cycles in WAIT_ACK; no output; next queued job issues.
- Push while FIFO at DEPTH-1 with simultaneous pop at issue -> count unchanged, no lost or duplicated job; pointer wrap verified over 10 jobs.
